// File: rtl/serial_adder_ctrl.sv
// Bit-serial sequencer around one shared 3-input ones-counter cell: presents one
// operand bit slice per step, holds it for SETTLE cycles, and feeds y1 back as carry.
module serial_adder_ctrl #(
    parameter int N      = 8,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         cell_a,
    output logic         cell_b,
    output logic         cell_c,
    input  logic         cell_y0,
    input  logic         cell_y1
);

    localparam int IW = $clog2(N);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    opa_reg, opa_next;
    logic [N-1:0]    opb_reg, opb_next;
    logic            carry_reg, carry_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [N-1:0]    sum_reg, sum_next;
    logic            cout_reg, cout_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            opa_reg   <= '0;
            opb_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            carry_reg <= carry_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        carry_next = carry_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        busy       = 1'b0;
        done       = 1'b0;
        cell_a     = 1'b0;
        cell_b     = 1'b0;
        cell_c     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    opa_next   = a_in;
                    opb_next   = b_in;
                    carry_next = cin;
                    idx_next   = '0;
                    cnt_next   = CNT_INIT;
                    sum_next   = '0;
                    cout_next  = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                cell_a = opa_reg[idx_reg];
                cell_b = opb_reg[idx_reg];
                cell_c = carry_reg;
                // The cell outputs are only trusted once the inputs have been held SETTLE cycles.
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    sum_next[idx_reg] = cell_y0;
                    carry_next        = cell_y1;
                    if (idx_reg == IDX_LAST) begin
                        cout_next  = cell_y1;
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                        cnt_next = CNT_INIT;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: four controllers (SETTLE = 1..4), each driving its own cell model
// whose outputs lag the inputs by SETTLE-1 cycles; results are checked against plain addition.
module tb_serial_adder_ctrl;

    localparam int N  = 8;
    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n   [NI];
    logic         start   [NI];
    logic [N-1:0] a_in    [NI];
    logic [N-1:0] b_in    [NI];
    logic         cin     [NI];
    logic         busy    [NI];
    logic         done    [NI];
    logic [N-1:0] sum     [NI];
    logic         cout    [NI];
    logic         cell_a  [NI];
    logic         cell_b  [NI];
    logic         cell_c  [NI];
    logic         cell_y0 [NI];
    logic         cell_y1 [NI];

    logic log_a [101];
    logic log_b [101];
    logic log_c [101];

    int checks   = 0;
    int failures = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int S = gi + 1;
            localparam int D = S - 1;
            logic y0_q [D+1];
            logic y1_q [D+1];
            assign y0_q[0] = cell_a[gi] ^ cell_b[gi] ^ cell_c[gi];
            assign y1_q[0] = (cell_a[gi] & cell_b[gi]) | (cell_a[gi] & cell_c[gi]) | (cell_b[gi] & cell_c[gi]);
            for (genvar k = 1; k <= D; k++) begin : g_dly
                always @(posedge clk) begin
                    y0_q[k] <= y0_q[k-1];
                    y1_q[k] <= y1_q[k-1];
                end
            end
            assign cell_y0[gi] = y0_q[D];
            assign cell_y1[gi] = y1_q[D];

            serial_adder_ctrl #(.N(N), .SETTLE(S)) dut (
                .clk     (clk),
                .rst_n   (rst_n[gi]),
                .start   (start[gi]),
                .a_in    (a_in[gi]),
                .b_in    (b_in[gi]),
                .cin     (cin[gi]),
                .busy    (busy[gi]),
                .done    (done[gi]),
                .sum     (sum[gi]),
                .cout    (cout[gi]),
                .cell_a  (cell_a[gi]),
                .cell_b  (cell_b[gi]),
                .cell_c  (cell_c[gi]),
                .cell_y0 (cell_y0[gi]),
                .cell_y1 (cell_y1[gi])
            );
        end
    endgenerate

    // Called at a negedge; returns at the negedge of the done cycle (or after 100 cycles).
    task automatic run_add(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           output int t_busy, output int t_done, output int nbusy,
                           output logic [N-1:0] s, output logic co);
        t_busy = 0;
        t_done = 0;
        nbusy  = 0;
        start[i] = 1'b1;
        a_in[i]  = a;
        b_in[i]  = b;
        cin[i]   = c;
        for (int t = 1; t <= 100 && t_done == 0; t++) begin
            @(negedge clk);
            log_a[t] = cell_a[i];
            log_b[t] = cell_b[i];
            log_c[t] = cell_c[i];
            if (busy[i]) begin
                nbusy++;
                if (t_busy == 0) t_busy = t;
                start[i] = 1'b0;
                a_in[i]  = N'($urandom);
                b_in[i]  = N'($urandom);
                cin[i]   = 1'($urandom);
            end
            if (done[i]) t_done = t;
        end
        start[i] = 1'b0;
        s  = sum[i];
        co = cout[i];
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0;
            start[i] = (i == 0);
            a_in[i]  = 8'hFF;
            b_in[i]  = 8'hFF;
            cin[i]   = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({busy[i], done[i], cout[i], cell_a[i], cell_b[i], cell_c[i]} !== 6'b0) begin
                failures++;
                $display("FAIL reset_ctrl inst=%0d got busy=%b done=%b cout=%b cells=%b%b%b want all 0",
                         i, busy[i], done[i], cout[i], cell_a[i], cell_b[i], cell_c[i]);
            end
            checks++;
            if (sum[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_sum inst=%0d got=%h want=00", i, sum[i]);
            end
        end
        start[0] = 1'b0;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_dropped got busy=%b want=0", busy[0]);
        end
        $display("reset: all instances cleared");
    endtask

    task automatic test_basic();
        int tb, td, nb;
        logic [N-1:0] s;
        logic co;
        run_add(0, 8'h5A, 8'h3C, 1'b0, tb, td, nb, s, co);
        $display("basic: 5a+3c+0 -> sum=%h cout=%b latency=%0d busy=%0d", s, co, td - tb + 1, nb);
        checks++;
        if (td == 0) begin failures++; $display("FAIL basic_timeout no done within 100 cycles"); end
        checks++;
        if ({co, s} !== 9'h096) begin failures++; $display("FAIL basic_result got=%h want=096", {co, s}); end
        checks++;
        if (tb != 1) begin failures++; $display("FAIL basic_accept got busy at cycle %0d want 1", tb); end
        checks++;
        if (td != 9) begin failures++; $display("FAIL basic_latency got=%0d want=9", td); end
        checks++;
        if (nb != 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=8", nb); end
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got done=%b want=0", done[0]); end
        checks++;
        if ({cout[0], sum[0]} !== 9'h096) begin
            failures++; $display("FAIL basic_hold got=%h want=096", {cout[0], sum[0]});
        end
    endtask

    task automatic test_back_to_back();
        int tb, td, nb;
        logic [N-1:0] s;
        logic co;
        run_add(0, 8'hFF, 8'h01, 1'b0, tb, td, nb, s, co);
        $display("b2b first: ff+01+0 -> sum=%h cout=%b", s, co);
        checks++;
        if ({co, s} !== 9'h100) begin failures++; $display("FAIL b2b_first got=%h want=100", {co, s}); end
        run_add(0, 8'hFF, 8'hFF, 1'b1, tb, td, nb, s, co);
        $display("b2b second: ff+ff+1 -> sum=%h cout=%b accept=%0d", s, co, tb);
        checks++;
        if ({co, s} !== 9'h1FF) begin failures++; $display("FAIL b2b_second got=%h want=1ff", {co, s}); end
        checks++;
        if (tb != 2) begin failures++; $display("FAIL b2b_accept got busy at cycle %0d want 2", tb); end
        checks++;
        if (td - tb + 1 != 9) begin failures++; $display("FAIL b2b_latency got=%0d want=9", td - tb + 1); end
        @(negedge clk);
    endtask

    task automatic test_settle3();
        int tb, td, nb, k, ai, bi, cy, bad;
        logic [N-1:0] s;
        logic co;
        run_add(2, 8'hA5, 8'h5A, 1'b1, tb, td, nb, s, co);
        $display("settle3: a5+5a+1 -> sum=%h cout=%b latency=%0d", s, co, td - tb + 1);
        checks++;
        if ({co, s} !== 9'h100) begin failures++; $display("FAIL settle3_result got=%h want=100", {co, s}); end
        checks++;
        if (td - tb + 1 != 25 || tb != 1) begin
            failures++; $display("FAIL settle3_latency got=%0d accept=%0d want=25 accept=1", td - tb + 1, tb);
        end
        ai = 32'hA5;
        bi = 32'h5A;
        bad = 0;
        for (int t = tb; t < td && t <= 100; t++) begin
            k  = (t - tb) / 3;
            cy = ((ai & ((1 << k) - 1)) + (bi & ((1 << k) - 1)) + 1) >> k;
            checks++;
            if ({log_a[t], log_b[t], log_c[t]} !== {ai[k], bi[k], cy[0]}) begin
                failures++;
                $display("FAIL settle3_cells cycle=%0d got=%b%b%b want=%b%b%b",
                         t, log_a[t], log_b[t], log_c[t], ai[k], bi[k], cy[0]);
            end
        end
        checks++;
        if (td > 0 && {log_a[td], log_b[td], log_c[td]} !== 3'b000) begin
            failures++; $display("FAIL settle3_cells_done got=%b%b%b want=000", log_a[td], log_b[td], log_c[td]);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int ndone, nbusy, tdone;
        logic [N:0] res;
        ndone = 0; nbusy = 0; tdone = 0; res = '0;
        start[0] = 1'b1; a_in[0] = 8'h12; b_in[0] = 8'h34; cin[0] = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (busy[0]) nbusy++;
            if (done[0]) begin ndone++; tdone = t; res = {cout[0], sum[0]}; end
            if (t == 1 || t == 4) start[0] = 1'b0;
            if (t == 3) begin start[0] = 1'b1; a_in[0] = 8'hEE; b_in[0] = 8'hEE; cin[0] = 1'b1; end
        end
        $display("start_ignored: 12+34+0 -> result=%h dones=%0d busy=%0d", res, ndone, nbusy);
        checks++;
        if (res !== 9'h046) begin failures++; $display("FAIL ignore_result got=%h want=046", res); end
        checks++;
        if (ndone != 1) begin failures++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
        checks++;
        if (tdone != 9 || nbusy != 8) begin
            failures++; $display("FAIL ignore_timing got done@%0d busy=%0d want done@9 busy=8", tdone, nbusy);
        end
    endtask

    task automatic test_reset_midrun();
        int tb, td, nb, ndone;
        logic [N-1:0] s, a, b;
        logic co, c;
        ndone = 0;
        start[0] = 1'b1; a_in[0] = 8'hFF; b_in[0] = 8'h00; cin[0] = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            if (done[0]) ndone++;
            if (t == 1) start[0] = 1'b0;
            if (t == 4) rst_n[0] = 1'b0;
        end
        $display("reset_midrun: busy=%b done=%b sum=%h cout=%b", busy[0], done[0], sum[0], cout[0]);
        checks++;
        if ({busy[0], done[0], cout[0], cell_a[0], cell_b[0], cell_c[0]} !== 6'b0 || ndone != 0) begin
            failures++;
            $display("FAIL midrun_ctrl got busy=%b done=%b cout=%b cells=%b%b%b dones=%0d want all 0",
                     busy[0], done[0], cout[0], cell_a[0], cell_b[0], cell_c[0], ndone);
        end
        checks++;
        if (sum[0] !== 8'h00) begin failures++; $display("FAIL midrun_sum got=%h want=00", sum[0]); end
        rst_n[0] = 1'b1;
        @(negedge clk);
        a = N'($urandom); b = N'($urandom); c = 1'($urandom);
        run_add(0, a, b, c, tb, td, nb, s, co);
        $display("reset_midrun fresh: %h+%h+%b -> %h", a, b, c, {co, s});
        checks++;
        if ({co, s} !== ({1'b0, a} + {1'b0, b} + {8'b0, c}) || td == 0) begin
            failures++;
            $display("FAIL midrun_fresh got=%h want=%h", {co, s}, {1'b0, a} + {1'b0, b} + {8'b0, c});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int i, tb, td, nb;
        logic [N-1:0] s, a, b;
        logic co, c;
        logic [N:0] want;
        for (int n = 0; n < 1000; n++) begin
            i = $urandom_range(0, 2);
            if (i == 2) i = 3;
            a = N'($urandom); b = N'($urandom); c = 1'($urandom);
            want = {1'b0, a} + {1'b0, b} + {8'b0, c};
            run_add(i, a, b, c, tb, td, nb, s, co);
            $display("rand %0d settle=%0d: %h+%h+%b -> %h", n, i + 1, a, b, c, {co, s});
            checks++;
            if ({co, s} !== want || td == 0) begin
                failures++; $display("FAIL rand_result n=%0d got=%h want=%h", n, {co, s}, want);
            end
            checks++;
            if (td - tb + 1 != N * (i + 1) + 1) begin
                failures++; $display("FAIL rand_latency n=%0d got=%0d want=%0d", n, td - tb + 1, N * (i + 1) + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; a_in[i] = '0; b_in[i] = '0; cin[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_settle3();
        test_start_ignored();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
